// File: rtl/baby_seq_pkg.sv
// baby_seq_pkg
// Shared types and constants for the Manchester Baby memory sequencer:
//   - state_e        : sequencer FSM states
//   - HDR_WE_BIT     : position of the write flag in the header byte
//   - ADDR_W         : core address width (header bits [4:0])
//   - BYTES_PER_WORD : data bytes per 32-bit word on the host link
//   - make_hdr()     : builds the header byte {we, 2'b00, addr}
package baby_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_STEP,
    ST_SETTLE,
    ST_HDR,
    ST_WDATA,
    ST_RDATA,
    ST_HALT,
    ST_ERROR
  } state_e;

  localparam int HDR_WE_BIT     = 7;
  localparam int ADDR_W         = 5;
  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_IDX_W     = $clog2(BYTES_PER_WORD);

  function automatic logic [7:0] make_hdr(input logic we, input logic [ADDR_W-1:0] addr);
    logic [7:0] h;
    h             = '0;
    h[HDR_WE_BIT] = we;
    h[ADDR_W-1:0] = addr;
    return h;
  endfunction

endpackage

// File: rtl/baby_seq_timeout.sv
// baby_seq_timeout
// Per-byte watchdog for the host link. A loadable down-counter:
//   clock     in  : system clock
//   reset_i   in  : synchronous active-high reset (count = 0)
//   clear_i   in  : reload the counter (start a fresh wait window)
//   en_i      in  : count one waiting cycle
//   expired_o out : this cycle is the last one allowed without a transfer
module baby_seq_timeout #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TO_W           = 10
) (
  input  logic clock,
  input  logic reset_i,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  // The window opens with the count at TIMEOUT_CYCLES-2, so it reaches zero on
  // the (TIMEOUT_CYCLES-1)th consecutive waiting cycle; that cycle is the limit.
  localparam logic [TO_W-1:0] LOAD_VAL = TO_W'(TIMEOUT_CYCLES - 2);

  logic [TO_W-1:0] count_q;
  logic [TO_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = LOAD_VAL;
    end else if (en_i && (count_q != '0)) begin
      count_d = count_q - TO_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = (count_q == '0);

endmodule

// File: rtl/baby_mem_sequencer.sv
// baby_mem_sequencer
// Steps the manchester_baby core one memory access at a time and services
// each access over a byte-wide valid/ready link to the host-side RAM.
// Ports:
//   clock, reset_i           : clock, synchronous active-high reset
//   run_i                    : level, allows stepping
//   stop_lamp_i              : core stop lamp (sampled only in IDLE)
//   core_addr_i/data_i/we_i  : core access request (latched after settle)
//   core_step_o              : one-cycle step pulse to the core
//   core_rdata_o             : read data held for the core
//   tx_data_o/valid_o/ready_i: bytes to host (header, then write data)
//   rx_data_i/valid_i/ready_o: bytes from host (read data)
//   busy_o/halted_o/error_o  : status
module baby_mem_sequencer
  import baby_seq_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TO_W           = 10
) (
  input  logic              clock,
  input  logic              reset_i,
  input  logic              run_i,
  input  logic              stop_lamp_i,
  input  logic [ADDR_W-1:0] core_addr_i,
  input  logic [31:0]       core_data_i,
  input  logic              core_we_i,
  output logic              core_step_o,
  output logic [31:0]       core_rdata_o,
  output logic [7:0]        tx_data_o,
  output logic              tx_valid_o,
  input  logic              tx_ready_i,
  input  logic [7:0]        rx_data_i,
  input  logic              rx_valid_i,
  output logic              rx_ready_o,
  output logic              busy_o,
  output logic              halted_o,
  output logic              error_o
);

  localparam logic [3:0]            SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [BYTE_IDX_W-1:0] LAST_BYTE   = BYTE_IDX_W'(BYTES_PER_WORD - 1);

  state_e                state_q, state_d;
  logic [3:0]            settle_cnt_q, settle_cnt_d;
  logic [BYTE_IDX_W-1:0] byte_idx_q, byte_idx_d;
  logic                  we_q, we_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           rdata_q, rdata_d;

  logic tx_fire;
  logic rx_fire;
  logic in_xfer;
  logic to_clear;
  logic to_expired;

  // Outputs decode from the state register only, so tx_data_o cannot move
  // while a byte is offered and not yet taken.
  always_comb begin
    core_step_o = (state_q == ST_STEP);
    tx_valid_o  = (state_q == ST_HDR) || (state_q == ST_WDATA);
    rx_ready_o  = (state_q == ST_RDATA);
    tx_data_o   = '0;
    if (state_q == ST_HDR) begin
      tx_data_o = make_hdr(we_q, addr_q);
    end else if (state_q == ST_WDATA) begin
      tx_data_o = wdata_q[{byte_idx_q, 3'b000} +: 8];
    end
    busy_o   = !(state_q inside {ST_IDLE, ST_HALT, ST_ERROR});
    halted_o = (state_q == ST_HALT);
    error_o  = (state_q == ST_ERROR);
  end

  assign tx_fire = tx_valid_o & tx_ready_i;
  assign rx_fire = rx_valid_i & rx_ready_o;
  assign in_xfer = state_q inside {ST_HDR, ST_WDATA, ST_RDATA};
  // Holding the counter reloaded outside the link states gives every entry
  // into HDR/WDATA/RDATA a fresh window; each accepted byte restarts it.
  assign to_clear = !in_xfer | tx_fire | rx_fire;

  baby_seq_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TO_W          (TO_W)
  ) u_timeout (
    .clock    (clock),
    .reset_i  (reset_i),
    .clear_i  (to_clear),
    .en_i     (in_xfer),
    .expired_o(to_expired)
  );

  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    byte_idx_d   = byte_idx_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (stop_lamp_i) begin
          state_d = ST_HALT;
        end else if (run_i) begin
          state_d = ST_STEP;
        end
      end

      ST_STEP: begin
        settle_cnt_d = '0;
        state_d      = ST_SETTLE;
      end

      ST_SETTLE: begin
        if (settle_cnt_q == SETTLE_LAST) begin
          we_d       = core_we_i;
          addr_d     = core_addr_i;
          wdata_d    = core_data_i;
          byte_idx_d = '0;
          state_d    = ST_HDR;
        end else begin
          settle_cnt_d = settle_cnt_q + 4'd1;
        end
      end

      ST_HDR: begin
        // A transfer on the limit cycle takes priority over the timeout.
        if (tx_fire) begin
          byte_idx_d = '0;
          state_d    = we_q ? ST_WDATA : ST_RDATA;
        end else if (to_expired) begin
          state_d = ST_ERROR;
        end
      end

      ST_WDATA: begin
        if (tx_fire) begin
          if (byte_idx_q == LAST_BYTE) begin
            byte_idx_d = '0;
            state_d    = ST_IDLE;
          end else begin
            byte_idx_d = byte_idx_q + BYTE_IDX_W'(1);
          end
        end else if (to_expired) begin
          state_d = ST_ERROR;
        end
      end

      ST_RDATA: begin
        if (rx_fire) begin
          rdata_d[{byte_idx_q, 3'b000} +: 8] = rx_data_i;
          if (byte_idx_q == LAST_BYTE) begin
            byte_idx_d = '0;
            state_d    = ST_IDLE;
          end else begin
            byte_idx_d = byte_idx_q + BYTE_IDX_W'(1);
          end
        end else if (to_expired) begin
          state_d = ST_ERROR;
        end
      end

      ST_HALT:  state_d = ST_HALT;
      ST_ERROR: state_d = ST_ERROR;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset_i) begin
      state_q      <= ST_IDLE;
      settle_cnt_q <= '0;
      byte_idx_q   <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      byte_idx_q   <= byte_idx_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
    end
  end

  assign core_rdata_o = rdata_q;

endmodule

// File: tb/tb_baby_mem_sequencer.sv
// tb_baby_mem_sequencer
// Directed and randomized checks of baby_mem_sequencer against a
// transaction-level host model: expected byte streams, read words, step
// counts and busy durations are computed from the access rules directly.
module tb_baby_mem_sequencer;

  localparam int SETTLE = 2;
  localparam int TMO    = 8;
  localparam int TOW    = 3;

  logic        clock = 1'b0;
  logic        reset_i;
  logic        run_i;
  logic        stop_lamp_i;
  logic [4:0]  core_addr_i;
  logic [31:0] core_data_i;
  logic        core_we_i;
  logic        core_step_o;
  logic [31:0] core_rdata_o;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i;
  logic [7:0]  rx_data_i;
  logic        rx_valid_i;
  logic        rx_ready_o;
  logic        busy_o;
  logic        halted_o;
  logic        error_o;

  int          n_asserts = 0;
  int          n_fail    = 0;
  logic [31:0] model_rdata;

  baby_mem_sequencer #(
    .SETTLE_CYCLES (SETTLE),
    .TIMEOUT_CYCLES(TMO),
    .TO_W          (TOW)
  ) dut (
    .clock       (clock),
    .reset_i     (reset_i),
    .run_i       (run_i),
    .stop_lamp_i (stop_lamp_i),
    .core_addr_i (core_addr_i),
    .core_data_i (core_data_i),
    .core_we_i   (core_we_i),
    .core_step_o (core_step_o),
    .core_rdata_o(core_rdata_o),
    .tx_data_o   (tx_data_o),
    .tx_valid_o  (tx_valid_o),
    .tx_ready_i  (tx_ready_i),
    .rx_data_i   (rx_data_i),
    .rx_valid_i  (rx_valid_i),
    .rx_ready_o  (rx_ready_o),
    .busy_o      (busy_o),
    .halted_o    (halted_o),
    .error_o     (error_o)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int pick_wait(input int max_wait, input int fixed_wait);
    if (fixed_wait >= 0) return fixed_wait;
    return int'($urandom_range(max_wait, 0));
  endfunction

  // One complete core access, acting as the host. Called at a negedge with the
  // DUT in IDLE (or already in STEP); returns at the negedge it is back in IDLE.
  task automatic access(input string name, input logic [4:0] a, input logic w,
                        input logic [31:0] d, input logic [31:0] rword,
                        input int max_wait, input int fixed_wait, input int stop_after);
    logic [7:0] txq[$];
    logic [7:0] expq[$];
    logic [7:0] prev_data;
    logic [31:0] obs;
    int steps, busy_cyc, waits, rx_k, wait_left;
    bit seen_busy, done, prev_stall;
    steps = 0; busy_cyc = 0; waits = 0; rx_k = 0;
    seen_busy = 0; done = 0; prev_stall = 0; prev_data = '0;
    core_addr_i = a; core_we_i = w; core_data_i = d; run_i = 1'b1;
    wait_left = pick_wait(max_wait, fixed_wait);
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (core_step_o) steps++;
      if (busy_o) begin
        seen_busy = 1;
        busy_cyc++;
      end else if (seen_busy) begin
        done = 1;
        break;
      end
      // Noise on handshakes that must be ignored unless the DUT is offering.
      tx_ready_i = 1'($urandom);
      rx_valid_i = 1'($urandom);
      rx_data_i  = 8'($urandom);
      if (tx_valid_o) begin
        if (prev_stall) check({name, " tx_stable"}, 32'(tx_data_o), 32'(prev_data));
        if (wait_left == 0) begin
          tx_ready_i = 1'b1;
          txq.push_back(tx_data_o);
          prev_stall = 0;
          wait_left = pick_wait(max_wait, fixed_wait);
          if (stop_after >= 0 && txq.size() == stop_after) stop_lamp_i = 1'b1;
        end else begin
          tx_ready_i = 1'b0;
          wait_left--;
          waits++;
          prev_stall = 1;
          prev_data = tx_data_o;
        end
      end else begin
        prev_stall = 0;
        if (rx_ready_o) begin
          if (wait_left == 0) begin
            rx_valid_i = 1'b1;
            rx_data_i  = rword[8*rx_k +: 8];
            rx_k++;
            wait_left = pick_wait(max_wait, fixed_wait);
          end else begin
            rx_valid_i = 1'b0;
            wait_left--;
            waits++;
          end
        end
      end
      @(negedge clock);
    end
    check({name, " done"}, 32'(done), 32'd1);
    expq.push_back({w, 2'b00, a});
    if (w) for (int k = 0; k < 4; k++) expq.push_back(d[8*k +: 8]);
    check({name, " tx_count"}, 32'(txq.size()), 32'(expq.size()));
    for (int k = 0; k < expq.size(); k++) begin
      obs = (k < txq.size()) ? 32'(txq[k]) : 32'hxxxx_xxxx;
      check({name, " tx_byte"}, obs, 32'(expq[k]));
    end
    check({name, " rx_count"}, 32'(rx_k), w ? 32'd0 : 32'd4);
    if (!w) model_rdata = rword;
    check({name, " rdata"}, core_rdata_o, model_rdata);
    check({name, " steps"}, 32'(steps), 32'd1);
    check({name, " busy_cycles"}, 32'(busy_cyc), 32'(1 + SETTLE + 5 + waits));
    check({name, " error"}, 32'(error_o), 32'd0);
    $display("access %-8s addr=%h we=%b wdata=%h rdata=%h busy=%0d waits=%0d",
             name, a, w, d, core_rdata_o, busy_cyc, waits);
  endtask

  initial begin
    int hdr_cycles;
    int rxk;
    bit aborted;
    reset_i = 1'b1; run_i = 1'b0; stop_lamp_i = 1'b0;
    core_addr_i = '0; core_data_i = '0; core_we_i = 1'b0;
    tx_ready_i = 1'b0; rx_valid_i = 1'b0; rx_data_i = '0;
    model_rdata = '0;

    // Reset state
    repeat (3) @(negedge clock);
    check("rst step", 32'(core_step_o), 32'd0);
    check("rst rdata", core_rdata_o, 32'd0);
    check("rst tx_valid", 32'(tx_valid_o), 32'd0);
    check("rst tx_data", 32'(tx_data_o), 32'd0);
    check("rst rx_ready", 32'(rx_ready_o), 32'd0);
    check("rst busy", 32'(busy_o), 32'd0);
    check("rst halted", 32'(halted_o), 32'd0);
    check("rst error", 32'(error_o), 32'd0);
    reset_i = 1'b0;

    // Directed read, zero-wait host
    access("read13", 5'h13, 1'b0, 32'h0, 32'h12345678, 0, 0, -1);
    // Directed write, host ready toggling 0/1
    access("write1f", 5'h1F, 1'b1, 32'hDEADBEEF, 32'h0, 0, 1, -1);

    // Randomized accesses, waits well inside the timeout window
    for (int i = 0; i < 20; i++) begin
      access("rand", 5'($urandom), 1'($urandom), $urandom, $urandom, 3, -1, -1);
    end

    // Pause: run low keeps the sequencer parked in IDLE
    run_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      check("pause busy", 32'(busy_o), 32'd0);
      check("pause step", 32'(core_step_o), 32'd0);
    end
    run_i = 1'b1;
    @(negedge clock);
    check("resume step", 32'(core_step_o), 32'd1);
    access("resume", 5'h02, 1'b0, 32'h0, 32'hCAFEF00D, 0, -1, -1);

    // Boundary: every byte accepted on the exact limit cycle
    access("limit", 5'h11, 1'b0, 32'h0, 32'h0BADC0DE, 0, TMO - 2, -1);
    access("limitw", 5'h04, 1'b1, 32'h13572468, 32'h0, 0, TMO - 2, -1);

    // Halt: stop lamp rises during WDATA, write still completes
    access("haltwr", 5'h0A, 1'b1, 32'h89ABCDEF, 32'h0, 0, 0, 3);
    @(negedge clock);
    check("halt halted", 32'(halted_o), 32'd1);
    check("halt busy", 32'(busy_o), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("halt no_step", 32'(core_step_o), 32'd0);
    end

    // Timeout: host never ready in HDR
    reset_i = 1'b1; run_i = 1'b0; stop_lamp_i = 1'b0;
    tx_ready_i = 1'b0; rx_valid_i = 1'b0;
    repeat (2) @(negedge clock);
    reset_i = 1'b0;
    model_rdata = '0;
    check("halt cleared", 32'(halted_o), 32'd0);
    run_i = 1'b1;
    hdr_cycles = 0;
    for (int c = 0; c < 40 && !error_o; c++) begin
      if (tx_valid_o) hdr_cycles++;
      @(negedge clock);
    end
    check("to error", 32'(error_o), 32'd1);
    check("to hdr_cycles", 32'(hdr_cycles), 32'(TMO - 1));
    check("to tx_valid", 32'(tx_valid_o), 32'd0);
    check("to busy", 32'(busy_o), 32'd0);
    @(negedge clock);
    check("to sticky", 32'(error_o), 32'd1);
    reset_i = 1'b1;
    @(negedge clock);
    check("to rst error", 32'(error_o), 32'd0);
    check("to rst tx_valid", 32'(tx_valid_o), 32'd0);
    check("to rst busy", 32'(busy_o), 32'd0);
    reset_i = 1'b0;
    $display("timeout hdr_cycles=%0d", hdr_cycles);

    // Reset during RDATA byte 2
    access("preread", 5'h05, 1'b0, 32'h0, 32'hA5C3F00F, 0, 0, -1);
    core_we_i = 1'b0; core_addr_i = 5'h07;
    rxk = 0; aborted = 0;
    for (int c = 0; c < 60; c++) begin
      tx_ready_i = 1'b1; rx_valid_i = 1'b0;
      if (rx_ready_o) begin
        if (rxk == 2) begin
          aborted = 1;
          break;
        end
        rx_valid_i = 1'b1;
        rx_data_i  = (rxk == 0) ? 8'h11 : 8'h22;
        rxk++;
      end
      @(negedge clock);
    end
    check("abort reached", 32'(aborted), 32'd1);
    check("abort partial", core_rdata_o, {model_rdata[31:16], 8'h22, 8'h11});
    reset_i = 1'b1; rx_valid_i = 1'b1; rx_data_i = 8'h33;
    @(negedge clock);
    check("abort busy", 32'(busy_o), 32'd0);
    check("abort rx_ready", 32'(rx_ready_o), 32'd0);
    check("abort rdata", core_rdata_o, 32'd0);
    check("abort tx_valid", 32'(tx_valid_o), 32'd0);
    reset_i = 1'b0; run_i = 1'b0; rx_valid_i = 1'b0;
    $display("abort rdata=%h", core_rdata_o);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
